// File: rtl/mux_pkg.sv
// Shared constants for the stream demultiplexer and its bench: drop-counter
// width, saturation ceiling and a saturating increment.
package mux_pkg;
    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        return (value == DROP_CNT_MAX) ? value : value + 1'b1;
    endfunction
endpackage

// File: rtl/demux_slot.sv
// Single-entry holding register for one output port. The parent guarantees
// that load is only raised when the slot is empty or draining on this edge.
module demux_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);
    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= data_in;
        end else if (ready) begin
            // Data stays put after a drain; only the valid flag drops.
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;
endmodule

// File: rtl/stream_demux.sv
// Routes one valid/ready input stream to N output ports by in_sel; beats aimed
// past the last port are discarded and counted.
module stream_demux
    import mux_pkg::*;
#(
    parameter int N = 9,
    parameter int M = 4,
    parameter int W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_data,
    input  logic [M-1:0]          in_sel,
    output logic [N-1:0]          out_valid,
    input  logic [N-1:0]          out_ready,
    output logic [N*W-1:0]        out_data,
    output logic                  drop_pulse,
    output logic [DROP_CNT_W-1:0] drop_count
);
    logic [N-1:0]            w_hit;
    logic [N-1:0]            w_busy;
    logic [N-1:0]            w_load;
    logic                    w_in_range;
    logic                    w_drop;
    logic                    r_drop_pulse;
    logic [DROP_CNT_W-1:0]   r_drop_count;

    // Only the addressed slot can block the input, so in_ready never looks
    // at any other port's state.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            assign w_hit[gi]  = (in_sel == M'(gi));
            assign w_busy[gi] = w_hit[gi] & out_valid[gi] & ~out_ready[gi];
            assign w_load[gi] = in_valid & in_ready & w_hit[gi];

            demux_slot #(.W(W)) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (w_load[gi]),
                .data_in (in_data),
                .ready   (out_ready[gi]),
                .valid   (out_valid[gi]),
                .data    (out_data[gi*W +: W])
            );
        end
    endgenerate

    assign in_ready   = ~|w_busy;
    assign w_in_range = |w_hit;
    assign w_drop     = in_valid & in_ready & ~w_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_pulse <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop) begin
                r_drop_count <= sat_inc(r_drop_count);
            end
        end
    end

    assign drop_pulse = r_drop_pulse;
    assign drop_count = r_drop_count;
endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: scenario tasks with inline checks plus
// a per-port scoreboard fed on input acceptance and drained on output transfers.
module tb_stream_demux;
    import mux_pkg::*;

    localparam int N = 9;
    localparam int M = 4;
    localparam int W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_data;
    logic [M-1:0]          in_sel;
    logic [N-1:0]          out_valid;
    logic [N-1:0]          out_ready;
    logic [N*W-1:0]        out_data;
    logic                  drop_pulse;
    logic [DROP_CNT_W-1:0] drop_count;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] sb_q [N][$];
    int           exp_cnt;
    logic         exp_pulse;

    stream_demux #(.N(N), .M(M), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: runs on the falling edge, where handshakes are stable.
    task automatic sb_monitor();
        logic [W-1:0] exp_d;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < N; i++) sb_q[i].delete();
                exp_cnt   = 0;
                exp_pulse = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (out_valid[i] && out_ready[i]) begin
                        checks++;
                        if (sb_q[i].size() == 0) begin
                            errors++;
                            $display("FAIL sb_unexpected port=%0d got=%h required=<none>", i, out_data[i*W +: W]);
                        end else begin
                            exp_d = sb_q[i].pop_front();
                            if (out_data[i*W +: W] !== exp_d) begin
                                errors++;
                                $display("FAIL sb_data port=%0d got=%h required=%h", i, out_data[i*W +: W], exp_d);
                            end
                        end
                    end
                end
                checks++;
                if (drop_count !== exp_cnt[DROP_CNT_W-1:0] || drop_pulse !== exp_pulse) begin
                    errors++;
                    $display("FAIL sb_drop got cnt=%0d pulse=%b required cnt=%0d pulse=%b",
                             drop_count, drop_pulse, exp_cnt, exp_pulse);
                end
                exp_pulse = 1'b0;
                if (in_valid && in_ready) begin
                    if (int'(in_sel) < N) begin
                        sb_q[in_sel].push_back(in_data);
                    end else begin
                        exp_pulse = 1'b1;
                        if (exp_cnt < int'(DROP_CNT_MAX)) exp_cnt++;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '1;
        #2;
        checks++;
        if (out_valid !== '0 || drop_pulse !== 1'b0 || drop_count !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state got valid=%h pulse=%b cnt=%0d data=%h required all zero",
                     out_valid, drop_pulse, drop_count, out_data);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_single_route();
        out_ready = '1;
        in_valid = 1'b1; in_sel = 4'd5; in_data = 4'hA;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL route_ready got=%b required=1", in_ready);
        end
        step();
        in_valid = 1'b0; in_sel = 4'd0; in_data = 4'h3;
        checks++;
        if (out_valid !== 9'h020 || out_data[23:20] !== 4'hA) begin
            errors++; $display("FAIL route_out got valid=%h data=%h required valid=020 data=a", out_valid, out_data[23:20]);
        end
        step();
        checks++;
        if (out_valid !== '0) begin
            errors++; $display("FAIL route_drain got=%h required=000", out_valid);
        end
        $display("test_single_route done");
    endtask

    task automatic test_backpressure();
        out_ready = '1; out_ready[3] = 1'b0;
        in_valid = 1'b1; in_sel = 4'd3; in_data = 4'h1;
        step();
        in_data = 4'h2;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall_ready got=%b required=0", in_ready);
        end
        step();
        checks++;
        if (out_valid[3] !== 1'b1 || out_data[15:12] !== 4'h1) begin
            errors++; $display("FAIL bp_hold got valid=%b data=%h required valid=1 data=1", out_valid[3], out_data[15:12]);
        end
        out_ready[3] = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_pass_ready got=%b required=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid[3] !== 1'b1 || out_data[15:12] !== 4'h2) begin
            errors++; $display("FAIL bp_replace got valid=%b data=%h required valid=1 data=2", out_valid[3], out_data[15:12]);
        end
        step();
        checks++;
        if (out_valid !== '0) begin
            errors++; $display("FAIL bp_drain got=%h required=000", out_valid);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_independent();
        out_ready = '1; out_ready[2] = 1'b0;
        in_valid = 1'b1; in_sel = 4'd2; in_data = 4'h6;
        step();
        in_sel = 4'd7; in_data = 4'h9;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL indep_ready got=%b required=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        out_ready[7] = 1'b0;
        checks++;
        if (out_valid !== 9'h084 || out_data[11:8] !== 4'h6 || out_data[31:28] !== 4'h9) begin
            errors++; $display("FAIL indep_out got valid=%h p2=%h p7=%h required valid=084 p2=6 p7=9",
                               out_valid, out_data[11:8], out_data[31:28]);
        end
        out_ready = '1;
        step();
        checks++;
        if (out_valid !== '0) begin
            errors++; $display("FAIL indep_drain got=%h required=000", out_valid);
        end
        $display("test_independent done");
    endtask

    task automatic test_drop();
        out_ready = '1;
        in_valid = 1'b1; in_sel = 4'd12; in_data = 4'hF;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL drop_ready got=%b required=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== '0 || drop_pulse !== 1'b1 || drop_count !== 8'd1) begin
            errors++; $display("FAIL drop_one got valid=%h pulse=%b cnt=%0d required valid=000 pulse=1 cnt=1",
                               out_valid, drop_pulse, drop_count);
        end
        step();
        checks++;
        if (drop_pulse !== 1'b0) begin
            errors++; $display("FAIL drop_pulse_width got=%b required=0", drop_pulse);
        end
        in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            in_sel  = M'($urandom_range(9, 15));
            in_data = W'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (drop_count !== DROP_CNT_MAX || out_valid !== '0) begin
            errors++; $display("FAIL drop_saturate got cnt=%0d valid=%h required cnt=255 valid=000", drop_count, out_valid);
        end
        $display("test_drop done");
    endtask

    task automatic test_reset_midstream();
        out_ready = '0;
        in_valid = 1'b1;
        in_sel = 4'd0; in_data = 4'h5; step();
        in_sel = 4'd4; in_data = 4'h7; step();
        in_sel = 4'd8; in_data = 4'hC; step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 9'h111) begin
            errors++; $display("FAIL mid_fill got=%h required=111", out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== '0 || drop_count !== '0 || out_data !== '0) begin
            errors++; $display("FAIL mid_reset got valid=%h cnt=%0d data=%h required all zero", out_valid, drop_count, out_data);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = '1;
        step();
        checks++;
        if (out_valid !== '0) begin
            errors++; $display("FAIL mid_after got=%h required=000", out_valid);
        end
        $display("test_reset_midstream done");
    endtask

    task automatic test_back_to_back();
        out_ready = '1;
        in_valid  = 1'b1;
        for (int k = 0; k < 64; k++) begin
            in_sel  = M'(k % N);
            in_data = W'($urandom);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_ready beat=%0d got=%b required=1", k, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (sb_q[i].size() != 0) begin
                errors++; $display("FAIL stream_left port=%0d got=%0d required=0", i, sb_q[i].size());
            end
        end
        checks++;
        if (out_valid !== '0) begin
            errors++; $display("FAIL stream_idle got=%h required=000", out_valid);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_single_route();
        test_backpressure();
        test_independent();
        test_drop();
        test_reset_midstream();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter N, default 9, meaning the number of output ports; legal range is 2..16.
REQ-002 SHALL have parameter M, default 4, meaning the select width; M SHALL equal ceil(log2(N)).
REQ-003 SHALL have parameter W, default 4, meaning the data width in bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an input beat.
REQ-008 SHALL have port in_data, input, W bits: the input payload.
REQ-009 SHALL have port in_sel, input, M bits: the destination port index.
REQ-010 SHALL have port out_valid, output, N bits: per-port valid, bit i for port i.
REQ-011 SHALL have port out_ready, input, N bits: per-port ready.
REQ-012 SHALL have port out_data, output, N*W bits: port i occupies bits [i*W+W-1 : i*W].
REQ-013 SHALL have port drop_pulse, output, 1 bit: an out-of-range beat was discarded.
REQ-014 SHALL have port drop_count, output, 8 bits: the number of discarded beats.

Function
REQ-015 SHALL contain one single-entry holding register per output port.
REQ-016 SHALL perform an input transfer when in_valid=1 and in_ready=1 are both high at a rising clk edge.
REQ-017 SHALL drive in_ready combinationally as follows:
- in_ready = 1 if in_sel >= N;
- in_ready = 1 if the slot selected by in_sel is empty;
- in_ready = 1 if that slot is full and out_ready[in_sel] = 1 in the same cycle;
- in_ready = 0 otherwise.
REQ-018 SHALL, on an in-range transfer, load in_data into slot in_sel and set out_valid[in_sel] on the next edge, giving 1-cycle latency.
REQ-019 SHALL ensure in_ready never depends on the state of any slot other than slot in_sel.
REQ-020 SHALL drive out_data for each port from its slot register and SHALL hold it stable while out_valid=1 and out_ready=0.
REQ-021 SHALL clear out_valid[i] on an output transfer (out_valid[i]=1, out_ready[i]=1) unless slot i is reloaded on the same edge.
REQ-022 SHALL, when a slot drains and reloads on the same edge, keep out_valid[i]=1 and load the new data, giving full throughput of one beat per cycle per port.
REQ-023 SHALL allow different ports to drain independently and simultaneously.
REQ-024 SHALL, on a transfer with in_sel >= N (possible only when N is not a power of two), discard the beat, load no slot, and assert drop_pulse for exactly one cycle on the next edge.
REQ-025 SHALL increment drop_count by 1 on each discarded beat and SHALL saturate it at 255 without wrapping.
REQ-026 SHALL give in_sel and in_data no effect while in_valid=0.
REQ-027 SHALL make output ordering per port equal to input acceptance order; no ordering is defined across ports.

Reset
REQ-028 SHALL, when rst_n=0, asynchronously clear out_valid to all zeros, drop_pulse to 0 and drop_count to 0.
REQ-029 SHALL clear out_data to zero under reset.
REQ-030 SHALL, when reset asserts mid-operation, lose any beat held in a slot without delivering it.
REQ-031 SHALL release reset synchronously to clk as seen by the slots; the first transfer is possible on the first edge after rst_n rises.

Structure
REQ-032 SHALL implement each holding register as sub-module demux_slot (parameter W; ports clk, rst_n, load, data_in, ready, valid, data), instantiated N times via a generate loop.
REQ-033 SHALL place the constants DROP_CNT_W=8 and DROP_CNT_MAX=255 in shared package mux_pkg, used by stream_demux and its bench.
REQ-034 SHALL keep all select decode in stream_demux; demux_slot contains no index logic.

Verification
REQ-035 SHALL cover the single route: N=9, W=4, in_sel=5, in_data=0xA, out_ready all 1 -> next cycle out_valid=9'h020, port-5 data=0xA, then out_valid=0.
REQ-036 SHALL cover backpressure: slot 3 full, out_ready[3]=0, in_sel=3 -> in_ready=0 and slot data held; raising out_ready[3] in the same cycle -> in_ready=1 and the new beat replaces the old with no bubble.
REQ-037 SHALL cover independent ports: slot 2 full and stalled, in_sel=7 -> in_ready=1 and port 7 is valid next cycle while port 2 remains unchanged.
REQ-038 SHALL cover drop handling: N=9, in_sel=12 with a transfer -> no out_valid change, drop_pulse=1 for 1 cycle, drop_count=1; 300 drops -> drop_count=255.
REQ-039 SHALL cover reset mid-stream: slots 0, 4 and 8 full, rst_n pulsed low between edges -> out_valid=0 immediately and drop_count=0.
REQ-040 SHALL cover streaming: 64 back-to-back beats with cycling in_sel 0..8 and all ready -> each port receives its beats in order at 1 beat per cycle with no loss.
